// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared geometry constants, sequencer states and address
//               packing helpers for the Life frame-memory row path.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    localparam int ROW_BITS    = 640;
    localparam int WORDS       = 40;
    localparam int ROWS        = 480;
    localparam int LINES       = 525;
    localparam int BLANK_START = 640;
    localparam int LINE_END    = 799;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Memory word address: {bank, rowIndex[8:0], word[5:0]}
    function automatic logic [15:0] pack_addr(input logic b, input logic [8:0] ri,
                                              input logic [5:0] w);
        return {b, ri, w};
    endfunction

    function automatic logic [15:0] row_word(input logic [ROW_BITS-1:0] r,
                                             input logic [5:0] w);
        return r[{w, 4'b0000} +: 16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_memory_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : row_memory_sequencer_if
// Description : Word request/response bus between the row sequencer and the
//               external 16-bit frame memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface row_memory_sequencer_if;

    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic        memGnt;
    logic [15:0] memRData;
    logic        memRValid;

    modport master (
        output memReq, memWe, memAddr, memWData,
        input  memGnt, memRData, memRValid
    );

    modport slave (
        input  memReq, memWe, memAddr, memWData,
        output memGnt, memRData, memRValid
    );

endinterface
`default_nettype wire

// File: rtl/row_shadow_buffer.sv
`default_nettype none
// ============================================================================
// Module      : row_shadow_buffer
// Description : 640-bit row store with whole-row load, 16-bit word write and
//               whole-row read.
// Revision    : 1.0 - initial release
// ============================================================================
module row_shadow_buffer
    import life_pkg::*;
(
    input  wire logic                clkDiv,
    input  wire logic                rst,
    input  wire logic                load,
    input  wire logic [ROW_BITS-1:0] load_row,
    input  wire logic                word_we,
    input  wire logic [5:0]          word_idx,
    input  wire logic [15:0]         word_data,
    output      logic [ROW_BITS-1:0] row_data
);

    logic [15:0] words [0:WORDS-1];

    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                words[i] <= 16'h0000;
            end
        end else if (load) begin
            for (int i = 0; i < WORDS; i++) begin
                words[i] <= load_row[16*i +: 16];
            end
        end else if (word_we && (word_idx < 6'(WORDS))) begin
            // Indices 40..63 address unused slots and are dropped
            words[word_idx] <= word_data;
        end
    end

    generate
        for (genvar i = 0; i < WORDS; i++) begin : g_pack
            assign row_data[16*i +: 16] = words[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/row_memory_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : row_memory_sequencer
// Description : Blanking-time mover: writes back the computed row, fetches the
//               row two lines ahead and presents it atomically on readRow.
// Revision    : 1.0 - initial release
// ============================================================================
module row_memory_sequencer
    import life_pkg::*;
(
    input  wire logic                clkDiv,
    input  wire logic                rst,
    input  wire logic [9:0]          row,
    input  wire logic [9:0]          column,
    input  wire logic [ROW_BITS-1:0] writeRow,
    output      logic [ROW_BITS-1:0] readRow,
    output      logic                reading,
    row_memory_sequencer_if.master   mem,
    output      logic                bank,
    output      logic                overrun
);

    localparam logic [5:0] LAST_WORD = 6'(WORDS - 1);

    seq_state_t          state;
    logic [5:0]          k;
    logic [5:0]          r;
    logic [8:0]          write_line;
    logic [8:0]          fetch_line;
    logic                fetch_ok;

    logic                trigger;
    logic                line_end;
    logic [8:0]          write_calc;
    logic [9:0]          fetch_calc;
    logic                write_calc_ok;
    logic                fetch_calc_ok;
    logic                rvalid_take;
    logic [ROW_BITS-1:0] wshadow_row;
    logic [ROW_BITS-1:0] rshadow_row;

    always_comb begin
        trigger       = (column == 10'(BLANK_START));
        line_end      = (column == 10'(LINE_END));
        write_calc    = 9'(row - 10'd1);
        fetch_calc    = row + 10'd2;
        if (fetch_calc >= 10'(LINES)) begin
            fetch_calc = fetch_calc - 10'(LINES);
        end
        write_calc_ok = (row >= 10'd1) && (row <= 10'(ROWS));
        fetch_calc_ok = (fetch_calc < 10'(ROWS));
        rvalid_take   = mem.memRValid && ((state == READ) || (state == DRAIN));
    end

    row_shadow_buffer u_wshadow (
        .clkDiv    (clkDiv),
        .rst       (rst),
        .load      (trigger && (state == IDLE)),
        .load_row  (writeRow),
        .word_we   (1'b0),
        .word_idx  (6'd0),
        .word_data (16'h0000),
        .row_data  (wshadow_row)
    );

    row_shadow_buffer u_rshadow (
        .clkDiv    (clkDiv),
        .rst       (rst),
        .load      (1'b0),
        .load_row  ('0),
        .word_we   (rvalid_take),
        .word_idx  (r),
        .word_data (mem.memRData),
        .row_data  (rshadow_row)
    );

    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k            <= 6'd0;
            r            <= 6'd0;
            write_line   <= 9'd0;
            fetch_line   <= 9'd0;
            fetch_ok     <= 1'b0;
            readRow      <= '0;
            reading      <= 1'b0;
            mem.memReq   <= 1'b0;
            mem.memWe    <= 1'b0;
            mem.memAddr  <= 16'h0000;
            mem.memWData <= 16'h0000;
            bank         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (line_end && (row == 10'(ROWS))) begin
                bank <= ~bank;
            end
            if ((trigger || line_end) && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (rvalid_take) begin
                r <= r + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        write_line <= write_calc;
                        fetch_line <= fetch_calc[8:0];
                        fetch_ok   <= fetch_calc_ok;
                        reading    <= 1'b0;
                        k          <= 6'd0;
                        r          <= 6'd0;
                        // Word 0 comes straight from writeRow; the shadow loads on this edge
                        if (write_calc_ok) begin
                            state        <= WRITE;
                            mem.memReq   <= 1'b1;
                            mem.memWe    <= 1'b1;
                            mem.memAddr  <= pack_addr(~bank, write_calc, 6'd0);
                            mem.memWData <= writeRow[15:0];
                        end else if (fetch_calc_ok) begin
                            state       <= READ;
                            mem.memReq  <= 1'b1;
                            mem.memWe   <= 1'b0;
                            mem.memAddr <= pack_addr(bank, fetch_calc[8:0], 6'd0);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem.memGnt) begin
                        if (k == LAST_WORD) begin
                            k         <= 6'd0;
                            mem.memWe <= 1'b0;
                            if (fetch_ok) begin
                                state       <= READ;
                                mem.memAddr <= pack_addr(bank, fetch_line, 6'd0);
                            end else begin
                                state      <= DONE;
                                mem.memReq <= 1'b0;
                            end
                        end else begin
                            k            <= k + 6'd1;
                            mem.memAddr  <= pack_addr(~bank, write_line, k + 6'd1);
                            mem.memWData <= row_word(wshadow_row, k + 6'd1);
                        end
                    end
                end
                READ: begin
                    if (mem.memGnt) begin
                        if (k == LAST_WORD) begin
                            k          <= 6'd0;
                            mem.memReq <= 1'b0;
                            state      <= DRAIN;
                        end else begin
                            k           <= k + 6'd1;
                            mem.memAddr <= pack_addr(bank, fetch_line, k + 6'd1);
                        end
                    end
                end
                DRAIN: begin
                    if ((r == 6'(WORDS)) || (rvalid_take && (r == LAST_WORD))) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Row and flag change on the same edge so no stale row is seen with reading high
                    readRow <= fetch_ok ? rshadow_row : '0;
                    reading <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_row_memory_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_memory_sequencer
// Description : Scoreboard bench for row_memory_sequencer with a latency-2
//               frame memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_memory_sequencer;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    logic         clkDiv = 1'b0;
    logic         rst;
    logic [9:0]   row;
    logic [9:0]   column;
    logic [639:0] writeRow;
    logic [639:0] readRow;
    logic         reading;
    logic         bank;
    logic         overrun;

    row_memory_sequencer_if mif ();

    row_memory_sequencer dut (
        .clkDiv   (clkDiv),
        .rst      (rst),
        .row      (row),
        .column   (column),
        .writeRow (writeRow),
        .readRow  (readRow),
        .reading  (reading),
        .mem      (mif),
        .bank     (bank),
        .overrun  (overrun)
    );

    always #5 clkDiv = ~clkDiv;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           rises   = 0;
    int           gcnt    = 0;
    bit           gmode   = 1'b0;
    bit           tb_bank = 1'b0;
    logic [15:0]  mem_model [0:65535];
    acc_t         exp_acc [$];
    logic [639:0] exp_rows [$];
    logic         s0v, s1v;
    logic [15:0]  s0d, s1d;
    logic         prev_req, prev_gnt, prev_reading;
    logic [15:0]  prev_addr, prev_data;
    logic [639:0] last_wr;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [639:0] rand_row();
        logic [639:0] v;
        for (int i = 0; i < 20; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [639:0] model_row(input bit b, input int ln);
        logic [639:0] v;
        for (int i = 0; i < 40; i++) v[16*i +: 16] = mem_model[{b, 9'(ln), 6'(i)}];
        return v;
    endfunction

    task automatic expect_line(input int ln);
        acc_t a;
        int   f;
        f = (ln + 2) % 525;
        if (ln >= 1 && ln <= 480) begin
            for (int i = 0; i < 40; i++) begin
                a.we   = 1'b1;
                a.addr = {~tb_bank, 9'(ln - 1), 6'(i)};
                a.data = writeRow[16*i +: 16];
                exp_acc.push_back(a);
            end
        end
        if (f < 480) begin
            for (int i = 0; i < 40; i++) begin
                a.we   = 1'b0;
                a.addr = {tb_bank, 9'(f), 6'(i)};
                a.data = 16'h0000;
                exp_acc.push_back(a);
            end
            exp_rows.push_back(model_row(tb_bank, f));
        end else begin
            exp_rows.push_back('0);
        end
    endtask

    task automatic clear_pipe();
        s0v = 1'b0; s1v = 1'b0; s0d = 16'h0; s1d = 16'h0;
        mif.memRValid = 1'b0;
        mif.memRData  = 16'h0;
        prev_req = 1'b0; prev_gnt = 1'b0;
        exp_acc.delete();
        exp_rows.delete();
    endtask

    // One clock: drive inputs at negedge, serve the memory, observe #1 after posedge
    task automatic cyc(input int ln, input int col);
        acc_t a;
        @(negedge clkDiv);
        row    = 10'(ln);
        column = 10'(col);
        gcnt++;
        mif.memGnt = gmode ? ((gcnt % 4) == 0) : 1'b1;
        if (prev_req && !prev_gnt) begin
            chk("hold_req",  mif.memReq,   1'b1);
            chk("hold_addr", mif.memAddr,  prev_addr);
            chk("hold_data", mif.memWData, prev_data);
        end
        prev_req  = mif.memReq;
        prev_gnt  = mif.memGnt;
        prev_addr = mif.memAddr;
        prev_data = mif.memWData;
        mif.memRValid = s1v;
        mif.memRData  = s1d;
        s1v = s0v; s1d = s0d;
        s0v = 1'b0; s0d = 16'h0;
        if (mif.memReq && mif.memGnt) begin
            chk("acc_expected", exp_acc.size() != 0, 1'b1);
            if (exp_acc.size() != 0) begin
                a = exp_acc.pop_front();
                chk("acc_we",   mif.memWe,   a.we);
                chk("acc_addr", mif.memAddr, a.addr);
                if (a.we) chk("acc_wdata", mif.memWData, a.data);
            end
            if (mif.memWe) begin
                mem_model[mif.memAddr] = mif.memWData;
            end else begin
                s0v = 1'b1;
                s0d = mem_model[mif.memAddr];
            end
        end
        @(posedge clkDiv);
        #1;
        if (reading && !prev_reading) begin
            rises++;
            chk("row_expected", exp_rows.size() != 0, 1'b1);
            if (exp_rows.size() != 0) chk("readRow", readRow, exp_rows.pop_front());
        end
        prev_reading = reading;
    endtask

    task automatic run_line(input int ln, input int c0, input int c1);
        writeRow = rand_row();
        last_wr  = writeRow;
        expect_line(ln);
        for (int c = c0; c <= c1; c++) begin
            cyc(ln, c);
            if (c == 645) writeRow = ~writeRow;
        end
    endtask

    task automatic do_reset();
        @(negedge clkDiv);
        rst = 1'b1;
        @(posedge clkDiv);
        #1;
        @(negedge clkDiv);
        rst = 1'b0;
        clear_pipe();
        tb_bank = 1'b0;
        prev_reading = 1'b0;
    endtask

    initial begin
        int rises_before;
        rst = 1'b1; row = 10'd0; column = 10'd0; writeRow = '0;
        mif.memGnt = 1'b0;
        prev_reading = 1'b0;
        clear_pipe();
        for (int i = 0; i < 65536; i++) mem_model[i] = 16'($urandom);

        repeat (3) @(posedge clkDiv);
        #1;
        chk("rst_readRow",  readRow,      '0);
        chk("rst_reading",  reading,      1'b0);
        chk("rst_memReq",   mif.memReq,   1'b0);
        chk("rst_memWe",    mif.memWe,    1'b0);
        chk("rst_memAddr",  mif.memAddr,  16'h0);
        chk("rst_memWData", mif.memWData, 16'h0);
        chk("rst_bank",     bank,         1'b0);
        chk("rst_overrun",  overrun,      1'b0);
        @(negedge clkDiv);
        rst = 1'b0;

        // Line 5: write row 4 to bank 1, fetch row 7 from bank 0
        run_line(5, 630, 799);
        chk("l5_reading", reading, 1'b1);
        chk("l5_overrun", overrun, 1'b0);
        chk("l5_rises",   rises,   1);
        chk("l5_left",    exp_acc.size(), 0);

        // Line 10: reset while reading
        writeRow = rand_row();
        expect_line(10);
        for (int c = 630; c <= 690; c++) cyc(10, c);
        chk("l10_in_read", {mif.memReq, mif.memWe}, 2'b10);
        @(negedge clkDiv);
        rst = 1'b1;
        @(posedge clkDiv);
        #1;
        chk("l10_rst_memReq",  mif.memReq, 1'b0);
        chk("l10_rst_reading", reading,    1'b0);
        chk("l10_rst_readRow", readRow,    '0);
        @(negedge clkDiv);
        rst = 1'b0;
        clear_pipe();
        tb_bank = 1'b0;
        prev_reading = reading;
        rises_before = rises;
        for (int c = 692; c <= 799; c++) cyc(10, c);
        chk("l10_no_done", reading, 1'b0);
        chk("l10_no_rise", rises,   rises_before);

        // Line 0: fetch only
        run_line(0, 630, 799);
        chk("l0_reading", reading, 1'b1);
        chk("l0_left",    exp_acc.size(), 0);

        // Line 478: write only, dead border row presented
        run_line(478, 630, 799);
        chk("l478_readRow", readRow, '0);
        chk("l478_reading", reading, 1'b1);
        chk("l478_left",    exp_acc.size(), 0);

        // Line 100 with sparse grants: transfer overruns the line
        gmode = 1'b1;
        run_line(100, 630, 799);
        chk("l100_overrun", overrun, 1'b1);
        for (int c = 0; c <= 639; c++) cyc(101, c);
        chk("l100_left",      exp_acc.size(),  0);
        chk("l100_rows_left", exp_rows.size(), 0);
        chk("l100_reading",   reading, 1'b1);
        gmode = 1'b0;
        do_reset();
        chk("l100_rst_overrun", overrun, 1'b0);

        // Frame end: bank swap, then wrap-around fetches
        run_line(480, 630, 798);
        chk("bank_before", bank, 1'b0);
        cyc(480, 799);
        chk("bank_after", bank, 1'b1);
        tb_bank = 1'b1;
        run_line(523, 630, 799);
        run_line(524, 630, 799);
        run_line(1, 630, 799);
        chk("l1_mem_row0",  model_row(1'b0, 0), last_wr);
        chk("fe_left",      exp_acc.size(),  0);
        chk("fe_rows_left", exp_rows.size(), 0);
        chk("fe_overrun",   overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/row_memory_sequencer.md
Name: row_memory_sequencer

Overview:
- Per-scanline memory mover between the external 16-bit frame memory and the Life row calculator.
- During horizontal blanking it does two things for the current generation:
  - writes the row the calculator just produced (640 bits) back to the next-generation bank;
  - fetches the row two lines ahead from the current-generation bank into a shadow buffer.
- It presents the fetched row atomically on readRow and raises reading for the calculator's edge detector.
- Bank (generation) swaps at frame end.

Parameters:
- ROW_BITS, 640, bits per row.
- WORDS, 40, 16-bit words per row (ROW_BITS/16).
- ROWS, 480, visible rows.
- LINES, 525, total lines per frame.
- BLANK_START, 640, column at which a transfer starts.
- LINE_END, 799, last column of a line.

Ports:
- clkDiv  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- row  in  10  current line 0..524.
- column  in  10  current column 0..799.
- writeRow  in  640  calculator's computed row.
- readRow  out  640  fetched row.
- reading  out  1  high from fetch completion to next transfer start.
- memReq  out  1  word request valid.
- memWe  out  1  1 = write, 0 = read (qualified by memReq).
- memAddr  out  16  {bank, rowIndex[8:0], word[5:0]}.
- memWData  out  16  write data.
- memGnt  in  1  request accepted this cycle.
- memRData  in  16  read data.
- memRValid  in  1  read data valid; in order, any latency ≥1.
- bank  out  1  current-generation bank (read side).
- overrun  out  1  sticky: transfer unfinished at LINE_END.

Behaviour:
- Reset values: readRow=0, reading=0, memReq=0, memWe=0, memAddr=0, memWData=0, bank=0, overrun=0, FSM=IDLE, all counters 0.
- Reset mid-transfer aborts immediately. There is no partial readRow update.
- Trigger: in IDLE when column==BLANK_START.
  - Snapshot writeRow into wShadow.
  - Compute W = row-1, valid when 1≤row≤ROWS.
  - Compute F = (row+2) mod LINES, valid when F<ROWS.
  - Deassert reading.
  - Next state: WRITE if W valid, else READ if F valid, else DONE.
- A trigger in any state other than IDLE sets overrun. The FSM is not restarted.
- WRITE:
  - memReq=1, memWe=1, memAddr={~bank, W, k}, memWData=wShadow[16k+15:16k].
  - k advances on memGnt only. Outputs stay stable while memGnt=0.
  - After the grant of k=WORDS-1, go to READ if F valid, else DONE.
- READ:
  - memReq=1, memWe=0, memAddr={bank, F, k}. k advances on memGnt.
  - Separate return counter r: each memRValid stores memRData into rShadow[16r+15:16r], then r++.
  - After the last grant, go to DRAIN.
- DRAIN: memReq=0. When r reaches WORDS (including a memRValid arriving in the same cycle), go to DONE.
- DONE: one cycle.
  - readRow <= rShadow if F valid, else all zeros (dead border rows).
  - reading <= 1 in the same cycle readRow updates, so the calculator never sees a stale row with reading high.
  - Return to IDLE.
- reading stays high until the next trigger.
- Bank swap: bank toggles on the clock where row==ROWS and column==LINE_END. No transfer is active then, because line ROWS has W=ROWS-1 and the transfer is finished by LINE_END.
- overrun also sets if the FSM is not in IDLE at column==LINE_END. Cleared only by rst.
- Budget: with single-cycle grant and latency ≤ 4, 80 words + drain fits in 160 blanking clocks.
- rowIndex is 9 bits, word index 6 bits; words 40..63 of each row slot are unused.

Decomposition:
- Shared package (life_pkg) holds ROW_BITS, WORDS, ROWS, LINES, BLANK_START, LINE_END, the FSM state enum {IDLE, WRITE, READ, DRAIN, DONE}, and the address-packing function.
- One natural sub-module: row_shadow_buffer. It holds 640-bit word-indexed storage with word write (index, data) and whole-row read, and is instantiated for both rShadow and wShadow.

Test Plan:
- Reset asserted mid-READ on line 10 → next clock memReq=0, reading=0, readRow=0; no DONE occurs.
- Line 5, memGnt always 1, memRValid 2 cycles after each grant:
  - 40 writes to {~bank,4,0..39};
  - then 40 reads from {bank,7,0..39};
  - reading rises exactly once with readRow equal to the model's row 7;
  - transfer done before column 799, overrun=0.
- Line 0 → no writes (W invalid), 40 reads of row 2.
- Line 478 → 40 writes of row 477, no reads (F=480 invalid), readRow=0, reading=1.
- memGnt toggling 1-of-4 cycles on line 100 → memAddr/memWData held stable while memGnt=0; transfer exceeds 160 clocks; overrun=1 at column 799.
- Frame end:
  - bank flips 0→1 at row 480, column 799;
  - line 523 fetches row 0 from bank 1;
  - line 524 fetches row 1;
  - writeRow written on line 1 lands at {0,0,k}.
